// File: rtl/iua_uart_cmd_rx.sv
// Host command receiver: 8N1 UART deserializer feeding a small command decoder
// that drives capture enable, LED debug mode and a one-cycle reset request.
module iua_uart_cmd_rx #(
  parameter int unsigned DIV = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  output logic       rx_ferr,
  output logic       rst_req,
  output logic       cap_en,
  output logic [1:0] led_mode
);
  localparam int unsigned   CW          = $clog2(DIV + 1);
  localparam logic [CW-1:0] RELOAD_BIT  = CW'(DIV);
  localparam logic [CW-1:0] RELOAD_HALF = CW'(DIV / 2);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
  } rx_state_t;

  typedef enum logic {
    C_IDLE, C_ARG
  } cmd_state_t;

  rx_state_t     rx_state_q, rx_state_d;
  cmd_state_t    cmd_state_q, cmd_state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_stb_q, rx_stb_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rst_req_q, rst_req_d;
  logic          cap_en_q, cap_en_d;
  logic [1:0]    led_mode_q, led_mode_d;
  logic          rxs;
  logic          sample;

  assign rxs    = sync2_q;
  assign sample = (cnt_q == '0);

  // After reset the line must sit high for a full bit period before a start
  // bit is accepted, so a frame cut by reset is not decoded from its middle.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    rx_data_d  = rx_data_q;
    rx_stb_d   = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!armed_q) begin
          if (!rxs)        cnt_d   = RELOAD_BIT;
          else if (sample) armed_d = 1'b1;
          else             cnt_d   = cnt_q - 1'b1;
        end else if (!rxs) begin
          cnt_d      = RELOAD_HALF;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (!sample) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxs) begin
          cnt_d      = RELOAD_BIT;
          idx_d      = 3'd0;
          rx_state_d = RX_DATA;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!sample) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = RELOAD_BIT;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!sample) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs) begin
          rx_stb_d   = 1'b1;
          rx_data_d  = shift_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_ferr_d  = 1'b1;
          rx_state_d = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rxs) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cmd_state_d = cmd_state_q;
    cap_en_d    = cap_en_q;
    led_mode_d  = led_mode_q;
    rst_req_d   = 1'b0;
    if (rx_stb_q) begin
      case (cmd_state_q)
        C_IDLE: begin
          case (rx_data_q)
            8'h52:   rst_req_d   = 1'b1;
            8'h53:   cap_en_d    = 1'b1;
            8'h50:   cap_en_d    = 1'b0;
            8'h4C:   cmd_state_d = C_ARG;
            default: cmd_state_d = C_IDLE;
          endcase
        end
        C_ARG: begin
          led_mode_d  = rx_data_q[1:0];
          cmd_state_d = C_IDLE;
        end
        default: cmd_state_d = C_IDLE;
      endcase
    end else if (rx_ferr_q && (cmd_state_q == C_ARG)) begin
      cmd_state_d = C_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cmd_state_q <= C_IDLE;
      cnt_q       <= RELOAD_BIT;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      armed_q     <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_stb_q    <= 1'b0;
      rx_ferr_q   <= 1'b0;
      rst_req_q   <= 1'b0;
      cap_en_q    <= 1'b0;
      led_mode_q  <= 2'b00;
    end else begin
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      rx_state_q  <= rx_state_d;
      cmd_state_q <= cmd_state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_stb_q    <= rx_stb_d;
      rx_ferr_q   <= rx_ferr_d;
      rst_req_q   <= rst_req_d;
      cap_en_q    <= cap_en_d;
      led_mode_q  <= led_mode_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_stb   = rx_stb_q;
  assign rx_ferr  = rx_ferr_q;
  assign rst_req  = rst_req_q;
  assign cap_en   = cap_en_q;
  assign led_mode = led_mode_q;
endmodule

// File: tb/tb_iua_uart_cmd_rx.sv
// Bench for iua_uart_cmd_rx: serial frames driven on uart_rx, expected bytes and
// command outputs queued by a reference model and checked by a monitor.
module tb_iua_uart_cmd_rx;
  localparam int BIT = 480;  // 24 clocks of 20 time units

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic       rx_ferr;
  logic       rst_req;
  logic       cap_en;
  logic [1:0] led_mode;

  iua_uart_cmd_rx #(.DIV(23)) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_stb   (rx_stb),
    .rx_ferr  (rx_ferr),
    .rst_req  (rst_req),
    .cap_en   (cap_en),
    .led_mode (led_mode)
  );

  // Clock and watchdog
  always #10 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard state: entry = {is_ferr, data[7:0], rst_req, cap_en, led_mode[1:0]}
  logic [12:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model of the command layer
  logic       m_cap = 1'b0;
  logic [1:0] m_led = 2'b00;
  logic       m_arg = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_good(input logic [7:0] b);
    logic rr;
    rr = 1'b0;
    if (m_arg) begin
      m_led = b[1:0];
      m_arg = 1'b0;
    end else if (b == "R") rr = 1'b1;
    else if (b == "S") m_cap = 1'b1;
    else if (b == "P") m_cap = 1'b0;
    else if (b == "L") m_arg = 1'b1;
    exp_q.push_back({1'b0, b, rr, m_cap, m_led});
  endtask

  task automatic expect_ferr();
    m_arg = 1'b0;
    exp_q.push_back({1'b1, 8'h00, 1'b0, m_cap, m_led});
  endtask

  // Driver tasks
  task automatic send_frame(input logic [7:0] b, input int bit_t, input int stop_low);
    uart_rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #(bit_t);
    end
    if (stop_low > 0) begin
      uart_rx = 1'b0;
      #(bit_t * stop_low);
    end
    uart_rx = 1'b1;
    #(bit_t);
  endtask

  task automatic send_good(input logic [7:0] b, input int bit_t);
    expect_good(b);
    send_frame(b, bit_t, 0);
  endtask

  task automatic send_bad(input logic [7:0] b, input int bit_t, input int stop_low);
    expect_ferr();
    send_frame(b, bit_t, stop_low);
  endtask

  task automatic idle(input int bits);
    uart_rx = 1'b1;
    #(BIT * bits);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},  16'(rx_data),  16'h0000);
    check({tag, "_rx_stb"},   16'(rx_stb),   16'h0000);
    check({tag, "_rx_ferr"},  16'(rx_ferr),  16'h0000);
    check({tag, "_rst_req"},  16'(rst_req),  16'h0000);
    check({tag, "_cap_en"},   16'(cap_en),   16'h0000);
    check({tag, "_led_mode"}, 16'(led_mode), 16'h0000);
  endtask

  // Monitor: pops one entry per strobe; command outputs are checked the cycle
  // after the strobe and must otherwise hold their last expected values.
  logic        mon_post = 1'b0;
  logic [3:0]  mon_pend = 4'h0;
  logic        mon_cap  = 1'b0;
  logic [1:0]  mon_led  = 2'b00;
  logic [12:0] mon_ev;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_post = 1'b0;
        mon_cap  = 1'b0;
        mon_led  = 2'b00;
      end else begin
        if (mon_post) begin
          check("cmd_rst_req",  16'(rst_req),  16'(mon_pend[3]));
          check("cmd_cap_en",   16'(cap_en),   16'(mon_pend[2]));
          check("cmd_led_mode", 16'(led_mode), 16'(mon_pend[1:0]));
          mon_cap  = mon_pend[2];
          mon_led  = mon_pend[1:0];
          mon_post = 1'b0;
        end else begin
          check("hold_rst_req",  16'(rst_req),  16'h0000);
          check("hold_cap_en",   16'(cap_en),   16'(mon_cap));
          check("hold_led_mode", 16'(led_mode), 16'(mon_led));
        end
        if (rx_stb || rx_ferr) begin
          check("stb_ferr_exclusive", 16'(rx_stb & rx_ferr), 16'h0000);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: stb=%b ferr=%b data=%h expected none at %0t",
                     rx_stb, rx_ferr, rx_data, $time);
          end else begin
            mon_ev = exp_q.pop_front();
            check("strobe_kind", 16'(rx_ferr), 16'(mon_ev[12]));
            if (!mon_ev[12]) check("rx_data", 16'(rx_data), 16'(mon_ev[11:4]));
            mon_pend = mon_ev[3:0];
            mon_post = 1'b1;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Single byte, framing error with recovery, glitch rejection
    send_good(8'hA5, BIT);
    idle(1);
    send_bad(8'h3C, BIT, 3);
    idle(1);
    send_good(8'h55, BIT);
    idle(1);
    uart_rx = 1'b0;
    #100;
    uart_rx = 1'b1;
    idle(2);
    send_good(8'h5A, BIT);
    idle(1);

    // Commands
    send_good("S", BIT);
    idle(1);
    send_good("P", BIT);
    idle(1);
    send_good("R", BIT);
    idle(1);
    send_good("L", BIT);
    send_good(8'hFE, BIT);
    idle(1);

    // Argument aborted by a framing error
    send_good("L", BIT);
    send_bad(8'h00, BIT, 1);
    idle(1);
    send_good(8'h03, BIT);
    idle(1);

    // Baud tolerance, back-to-back at about -2% then +2% bit period
    for (int i = 0; i < 16; i++) begin
      send_good(8'($urandom_range(0, 255)), (i < 8) ? 470 : 490);
    end
    idle(2);

    // Randomized mix of commands, plain bytes and framing errors
    for (int i = 0; i < 24; i++) begin
      int sel;
      int bt;
      logic [7:0] b;
      sel = $urandom_range(0, 6);
      bt  = BIT - 4 + $urandom_range(0, 8);
      b   = 8'($urandom_range(0, 255));
      case (sel)
        0: send_good("R", bt);
        1: send_good("S", bt);
        2: send_good("P", bt);
        3: send_good("L", bt);
        4: send_bad(b, bt, $urandom_range(1, 2));
        default: send_good(b, bt);
      endcase
      idle($urandom_range(0, 2));
    end

    // Asynchronous reset during bit 4 of a frame, released during bit 5
    send_good("S", BIT);
    send_good("L", BIT);
    send_good(8'h01, BIT);
    idle(2);
    uart_rx = 1'b0;
    #(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rx = 1'b1;
      #(BIT);
    end
    uart_rx = 1'b0;
    #(BIT / 2);
    rst = 1'b1;
    m_cap = 1'b0;
    m_led = 2'b00;
    m_arg = 1'b0;
    #1;
    check_reset_outputs("midframe_rst");
    #(BIT / 2 - 1);
    #(BIT / 2);
    rst = 1'b0;
    #(BIT / 2);
    #(BIT * 2);
    uart_rx = 1'b1;
    #(BIT);
    idle(2);
    send_good("S", BIT);
    idle(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_strobes: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
